id_stage_pipe: RTL and testbench

//  Parametrised decode stage plus ID/EXE pipeline register. Decodes the 16-bit instruction, drives

---
 rtl/id_stage_pipe_if.sv | 46 ++++
 rtl/id_stage_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// IF->ID and ID->EXE signal bundle for id_stage_pipe.
// slave: the decode stage itself; master: the surrounding pipeline.
interface id_stage_pipe_if #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4,
  parameter int EXE_CMD_LEN  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [15:0]             instruction;
  logic [WORD_LEN-1:0]     pc_in;
  logic [REG_ADDR_LEN-1:0] src1_addr;
  logic [REG_ADDR_LEN-1:0] src2_addr;
  logic [WORD_LEN-1:0]     reg1;
  logic [WORD_LEN-1:0]     reg2;
  logic                    hazard_detected;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXE_CMD_LEN-1:0]  exe_cmd;
  logic                    wb_en;
  logic                    mem_r_en;
  logic                    mem_w_en;
  logic                    is_imm;
  logic [REG_ADDR_LEN-1:0] dest;
  logic [REG_ADDR_LEN-1:0] src1;
  logic [REG_ADDR_LEN-1:0] src2_forw;
  logic [WORD_LEN-1:0]     val1;
  logic [WORD_LEN-1:0]     val2;
  logic [WORD_LEN-1:0]     st_val;
  logic                    br_taken;
  logic [WORD_LEN-1:0]     br_target;
  logic                    illegal;

  modport slave (
    input  in_valid, instruction, pc_in, reg1, reg2, hazard_detected, flush, out_ready,
    output in_ready, src1_addr, src2_addr, out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en,
           is_imm, dest, src1, src2_forw, val1, val2, st_val, br_taken, br_target, illegal
  );

  modport master (
    output in_valid, instruction, pc_in, reg1, reg2, hazard_detected, flush, out_ready,
    input  in_ready, src1_addr, src2_addr, out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en,
           is_imm, dest, src1, src2_forw, val1, val2, st_val, br_taken, br_target, illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage + ID/EXE register: decodes 16-bit instructions, resolves branches in ID, squashes
// wrong-path slots. Optional write-back bypass into the read operands: define ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4,
  parameter int EXE_CMD_LEN  = 4,
  parameter int SQUASH_SLOTS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ID_WB_BYPASS_EN
  input  logic                    wb_bypass_en,
  input  logic [REG_ADDR_LEN-1:0] wb_bypass_dest,
  input  logic [WORD_LEN-1:0]     wb_bypass_val,
`endif
  id_stage_pipe_if.slave          bus
);

  localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(0);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SLL = EXE_CMD_LEN'(4);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEZ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_SLL  = 4'hB;

  localparam logic [1:0] SQUASH_INIT = 2'(SQUASH_SLOTS);

  logic [15:0]             instr;
  logic [3:0]              opcode;
  logic [WORD_LEN-1:0]     imm4, off8, off12;

  logic [EXE_CMD_LEN-1:0]  d_cmd;
  logic                    d_wb, d_mem_r, d_mem_w, d_imm, d_illegal;
  logic                    d_bez, d_bne, d_jmp, d_taken;
  logic [REG_ADDR_LEN-1:0] d_dest, d_rs1, d_rs2;
  logic [WORD_LEN-1:0]     d_off;
  logic [WORD_LEN-1:0]     reg1_eff, reg2_eff;

  logic [1:0]              squash_cnt;
  logic                    in_ready_int;
  logic                    accept;

  assign instr  = bus.instruction;
  assign opcode = instr[15:12];
  assign imm4   = {{(WORD_LEN-4){instr[3]}},  instr[3:0]};
  assign off8   = {{(WORD_LEN-8){instr[7]}},  instr[7:0]};
  assign off12  = {{(WORD_LEN-12){instr[11]}}, instr[11:0]};

  always_comb begin
    d_cmd     = CMD_ADD;
    d_wb      = 1'b0;
    d_mem_r   = 1'b0;
    d_mem_w   = 1'b0;
    d_imm     = 1'b0;
    d_illegal = 1'b0;
    d_bez     = 1'b0;
    d_bne     = 1'b0;
    d_jmp     = 1'b0;
    d_dest    = '0;
    d_rs1     = '0;
    d_rs2     = '0;
    d_off     = '0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d_wb   = 1'b1;
        d_dest = instr[11:8];
        d_rs1  = instr[7:4];
        d_rs2  = instr[3:0];
        d_cmd  = (opcode == OP_SUB) ? CMD_SUB :
                 (opcode == OP_AND) ? CMD_AND :
                 (opcode == OP_OR)  ? CMD_OR  : CMD_ADD;
      end
      OP_ADDI, OP_LD, OP_SLL: begin
        d_wb    = 1'b1;
        d_imm   = 1'b1;
        d_mem_r = (opcode == OP_LD);
        d_cmd   = (opcode == OP_SLL) ? CMD_SLL : CMD_ADD;
        d_dest  = instr[11:8];
        d_rs1   = instr[7:4];
      end
      // Store reads its data register on port 2 so it can ride along as st_val.
      OP_ST: begin
        d_imm   = 1'b1;
        d_mem_w = 1'b1;
        d_rs1   = instr[7:4];
        d_rs2   = instr[11:8];
      end
      OP_BEZ: begin
        d_bez = 1'b1;
        d_rs1 = instr[11:8];
        d_off = off8;
      end
      OP_BNE: begin
        d_bne = 1'b1;
        d_rs1 = instr[11:8];
        d_rs2 = instr[7:4];
        d_off = imm4;
      end
      OP_JMP: begin
        d_jmp = 1'b1;
        d_off = off12;
      end
      default: d_illegal = 1'b1;
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  assign reg1_eff = (wb_bypass_en && (d_rs1 != '0) && (wb_bypass_dest == d_rs1)) ? wb_bypass_val : bus.reg1;
  assign reg2_eff = (wb_bypass_en && (d_rs2 != '0) && (wb_bypass_dest == d_rs2)) ? wb_bypass_val : bus.reg2;
`else
  assign reg1_eff = bus.reg1;
  assign reg2_eff = bus.reg2;
`endif

  assign d_taken = d_jmp | (d_bez & (reg1_eff == '0)) | (d_bne & (reg1_eff != reg2_eff));

  assign bus.src1_addr = d_rs1;
  assign bus.src2_addr = d_rs2;

  // Handshake: a beat moves on a side when its valid and ready are both high at the rising edge;
  // valid never depends on ready, and a stalled ID/EXE register keeps every output stable.
  // flush wins over a same-cycle input transfer: the beat is consumed and discarded.
  assign in_ready_int = rst & ~bus.hazard_detected & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = in_ready_int;
  assign accept       = bus.in_valid & in_ready_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.exe_cmd   <= '0;
      bus.wb_en     <= 1'b0;
      bus.mem_r_en  <= 1'b0;
      bus.mem_w_en  <= 1'b0;
      bus.is_imm    <= 1'b0;
      bus.dest      <= '0;
      bus.src1      <= '0;
      bus.src2_forw <= '0;
      bus.val1      <= '0;
      bus.val2      <= '0;
      bus.st_val    <= '0;
      bus.br_taken  <= 1'b0;
      bus.br_target <= '0;
      bus.illegal   <= 1'b0;
      squash_cnt    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.mem_r_en  <= 1'b0;
      bus.mem_w_en  <= 1'b0;
      bus.br_taken  <= 1'b0;
      squash_cnt    <= '0;
    end else begin
      bus.br_taken <= 1'b0;
      if (accept && (squash_cnt != 2'd0)) begin
        // Wrong-path slot: consumed from IF but never handed to EXE.
        squash_cnt    <= squash_cnt - 2'd1;
        bus.out_valid <= 1'b0;
        bus.wb_en     <= 1'b0;
        bus.mem_r_en  <= 1'b0;
        bus.mem_w_en  <= 1'b0;
      end else if (accept) begin
        bus.out_valid <= 1'b1;
        bus.exe_cmd   <= d_cmd;
        bus.wb_en     <= d_wb;
        bus.mem_r_en  <= d_mem_r;
        bus.mem_w_en  <= d_mem_w;
        bus.is_imm    <= d_imm;
        bus.dest      <= d_dest;
        bus.src1      <= d_rs1;
        bus.src2_forw <= d_imm ? '0 : d_rs2;
        bus.val1      <= reg1_eff;
        bus.val2      <= d_imm ? imm4 : reg2_eff;
        bus.st_val    <= reg2_eff;
        bus.illegal   <= d_illegal;
        if (d_taken) begin
          bus.br_taken  <= 1'b1;
          bus.br_target <= bus.pc_in + d_off;
          squash_cnt    <= SQUASH_INIT;
        end
      end else if (!bus.out_valid || bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.wb_en     <= 1'b0;
        bus.mem_r_en  <= 1'b0;
        bus.mem_w_en  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios then randomized traffic, all checked
// against a transaction-level reference model and an expected-output queue.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  localparam int WL = 16;
  localparam int RL = 4;
  localparam int CL = 4;
  localparam int SQ = 1;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        wb, mr, mw, imm, ill;
    logic [3:0]  dest, s1, s2f;
    logic [15:0] v1, v2, st;
  } item_t;
  localparam int ITEM_W = $bits(item_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.WORD_LEN(WL), .REG_ADDR_LEN(RL), .EXE_CMD_LEN(CL)) bus();

`ifdef ID_WB_BYPASS_EN
  logic        bp_en   = 1'b0;
  logic [3:0]  bp_dest = '0;
  logic [15:0] bp_val  = '0;
`endif

  id_stage_pipe #(.WORD_LEN(WL), .REG_ADDR_LEN(RL), .EXE_CMD_LEN(CL), .SQUASH_SLOTS(SQ)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ID_WB_BYPASS_EN
    .wb_bypass_en(bp_en),
    .wb_bypass_dest(bp_dest),
    .wb_bypass_val(bp_val),
`endif
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int                n_cmp = 0;
  int                n_err = 0;
  logic [ITEM_W-1:0] exp_q[$];
  int                sq_cnt = 0;
  logic              exp_br = 1'b0;
  logic [15:0]       exp_tgt = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic item_t model_decode(input logic [15:0] ins, input logic [15:0] pc,
                                         input logic [15:0] r1_raw, input logic [15:0] r2_raw,
                                         output logic [3:0] a1, output logic [3:0] a2,
                                         output logic tk, output logic [15:0] tgt);
    item_t       it;
    int          op, off, imm_i;
    logic [15:0] r1, r2;
    it  = '0;
    op  = int'(ins[15:12]);
    a1  = '0;
    a2  = '0;
    tk  = 1'b0;
    off = 0;
    case (op)
      1, 2, 3, 4: begin
        it.cmd = 4'(op - 1); it.wb = 1'b1; it.dest = ins[11:8]; a1 = ins[7:4]; a2 = ins[3:0];
      end
      5, 6, 11: begin
        it.cmd = (op == 11) ? 4'd4 : 4'd0; it.wb = 1'b1; it.imm = 1'b1; it.mr = (op == 6);
        it.dest = ins[11:8]; a1 = ins[7:4];
      end
      7: begin it.imm = 1'b1; it.mw = 1'b1; a1 = ins[7:4]; a2 = ins[11:8]; end
      8: a1 = ins[11:8];
      9: begin a1 = ins[11:8]; a2 = ins[7:4]; end
      12, 13, 14, 15: it.ill = 1'b1;
      default: ;
    endcase
    r1 = r1_raw;
    r2 = r2_raw;
`ifdef ID_WB_BYPASS_EN
    if (bp_en && a1 != 4'd0 && bp_dest == a1) r1 = bp_val;
    if (bp_en && a2 != 4'd0 && bp_dest == a2) r2 = bp_val;
`endif
    case (op)
      8:  begin tk = (r1 == 16'd0); off = int'($signed(ins[7:0]));  end
      9:  begin tk = (r1 != r2);    off = int'($signed(ins[3:0]));  end
      10: begin tk = 1'b1;          off = int'($signed(ins[11:0])); end
      default: ;
    endcase
    tgt    = 16'(int'(pc) + off);
    imm_i  = int'($signed(ins[3:0]));
    it.s1  = a1;
    it.s2f = it.imm ? 4'd0 : a2;
    it.v1  = r1;
    it.v2  = it.imm ? 16'(imm_i) : r2;
    it.st  = r2;
    return it;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [15:0] r1, input logic [15:0] r2,
                       input logic hz, input logic fl, input logic ordy);
    item_t       it, e;
    logic [3:0]  a1, a2;
    logic        tk, mv, rdy, acc;
    logic [15:0] tgt;
    bus.in_valid        = iv;
    bus.instruction     = ins;
    bus.pc_in           = pc;
    bus.reg1            = r1;
    bus.reg2            = r2;
    bus.hazard_detected = hz;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    #1;
    it  = model_decode(ins, pc, r1, r2, a1, a2, tk, tgt);
    mv  = (exp_q.size() != 0);
    rdy = !hz && (!mv || ordy);
    check_eq("in_ready", bus.in_ready, rdy);
    check_eq("src1_addr", bus.src1_addr, a1);
    check_eq("src2_addr", bus.src2_addr, a2);
    acc    = iv && rdy;
    exp_br = 1'b0;
    if (fl) begin
      exp_q.delete();
      sq_cnt = 0;
    end else begin
      if (mv && ordy) void'(exp_q.pop_front());
      if (acc) begin
        if (sq_cnt > 0) sq_cnt--;
        else begin
          exp_q.push_back(it);
          if (tk) begin exp_br = 1'b1; exp_tgt = tgt; sq_cnt = SQ; end
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("ctrl", {bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.is_imm, bus.illegal,
                        bus.dest, bus.src1, bus.src2_forw},
                       {e.cmd, e.wb, e.mr, e.mw, e.imm, e.ill, e.dest, e.s1, e.s2f});
      check_eq("val1", bus.val1, e.v1);
      check_eq("val2", bus.val2, e.v2);
      check_eq("st_val", bus.st_val, e.st);
    end
    check_eq("br_taken", bus.br_taken, exp_br);
    if (exp_br) check_eq("br_target", bus.br_target, exp_tgt);
  endtask

  task automatic rand_cycle();
    logic [15:0] ins, r1, r2;
    ins = 16'($urandom);
    r1  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    r2  = ($urandom_range(0, 3) == 0) ? r1 : 16'($urandom);
`ifdef ID_WB_BYPASS_EN
    bp_en   = ($urandom_range(0, 2) == 0);
    bp_dest = 4'($urandom_range(0, 15));
    bp_val  = 16'($urandom);
`endif
    cycle($urandom_range(0, 3) != 0, ins, 16'($urandom), r1, r2,
          $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, {bus.out_valid, bus.in_ready, bus.exe_cmd, bus.wb_en, bus.mem_r_en,
                              bus.mem_w_en, bus.is_imm, bus.dest, bus.src1, bus.src2_forw,
                              bus.br_taken, bus.illegal}, 64'd0);
    check_eq({tag, "_data"}, {bus.val1, bus.val2, bus.st_val, bus.br_target}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid        = 1'b0;
    bus.instruction     = '0;
    bus.pc_in           = '0;
    bus.reg1            = '0;
    bus.reg2            = '0;
    bus.hazard_detected = 1'b0;
    bus.flush           = 1'b0;
    bus.out_ready       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 30; i++) rand_cycle();

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    sq_cnt = 0;
    exp_br = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst = 1'b1;

    // ADD r3,r1,r2
    cycle(1'b1, 16'h1312, 16'd1, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
    check_eq("t1_valid", bus.out_valid, 1'b1);
    check_eq("t1_cmd", bus.exe_cmd, 4'd0);
    check_eq("t1_dest", bus.dest, 4'd3);
    check_eq("t1_val1", bus.val1, 16'd5);
    check_eq("t1_val2", bus.val2, 16'd7);
    check_eq("t1_wb", bus.wb_en, 1'b1);

    // ADDI r2,r1,#-1
    cycle(1'b1, 16'h521F, 16'd2, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b1);
    check_eq("t2_imm", bus.is_imm, 1'b1);
    check_eq("t2_val2", bus.val2, 16'hFFFF);
    check_eq("t2_src2f", bus.src2_forw, 4'd0);

    // BEZ r1,#+4 taken, then one squashed slot, then normal flow
    cycle(1'b1, 16'h8104, 16'd10, 16'd0, 16'h0055, 1'b0, 1'b0, 1'b1);
    check_eq("t3_br", bus.br_taken, 1'b1);
    check_eq("t3_tgt", bus.br_target, 16'd14);
    check_eq("t3_brvalid", bus.out_valid, 1'b1);
    cycle(1'b1, 16'h1312, 16'd11, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
    check_eq("t3_squash", bus.out_valid, 1'b0);
    check_eq("t3_pulse_end", bus.br_taken, 1'b0);
    cycle(1'b1, 16'h1456, 16'd12, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1);
    check_eq("t3_resume", bus.out_valid, 1'b1);
    check_eq("t3_dest", bus.dest, 4'd4);

    // LD held by two hazard cycles
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 16'h6A32, 16'd13, 16'd100, 16'd0, 1'b1, 1'b0, 1'b1);
      check_eq("t4_bubble", bus.out_valid, 1'b0);
      check_eq("t4_ready", bus.in_ready, 1'b0);
    end
    cycle(1'b1, 16'h6A32, 16'd13, 16'd100, 16'd0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_ld_valid", bus.out_valid, 1'b1);
    check_eq("t4_ld_mr", bus.mem_r_en, 1'b1);
    check_eq("t4_ld_val2", bus.val2, 16'd2);

    // SUB r3,r2,r1 stalled three cycles, then flushed
    cycle(1'b1, 16'h2321, 16'd20, 16'd30, 16'd8, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h1111, 16'd21, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
      check_eq("t5_frozen_val1", bus.val1, 16'd30);
      check_eq("t5_frozen_cmd", bus.exe_cmd, 4'd1);
    end
    cycle(1'b1, 16'h1111, 16'd21, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
    check_eq("t5_flush", bus.out_valid, 1'b0);

    // Illegal opcode 0xD
    cycle(1'b1, 16'hD123, 16'd30, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1);
    check_eq("t6_valid", bus.out_valid, 1'b1);
    check_eq("t6_illegal", bus.illegal, 1'b1);
    check_eq("t6_wb", bus.wb_en, 1'b0);
    check_eq("t6_mw", bus.mem_w_en, 1'b0);

`ifdef ID_WB_BYPASS_EN
    bp_en   = 1'b1;
    bp_dest = 4'd1;
    bp_val  = 16'd9;
    cycle(1'b1, 16'h1412, 16'd31, 16'd3, 16'd4, 1'b0, 1'b0, 1'b1);
    check_eq("t6_bypass_val1", bus.val1, 16'd9);
    bp_en = 1'b0;
`endif

    for (int i = 0; i < 400; i++) rand_cycle();
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
